// File: rtl/uart_tx_framer.sv
// Serial transmit framer: accepts a byte over ready/valid and shifts out the
// 11-bit frame {stop, parity, data, start} LSB first, CLKS_PER_BIT clocks per bit.
module uart_tx_framer #(
   parameter int CLKS_PER_BIT = 5208,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tx_start,
   input  logic [7:0]  tx_data,
   output logic        tx_ready,
   output logic        tx_busy,
   output logic        tx_serial,
   output logic        done_flag,
   output logic [10:0] frame_out
);

   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST_BIT  = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_idx;
   logic [3:0]    next_idx;
   logic          par;

   assign par      = PARITY_ODD ? ~^tx_data : ^tx_data;
   assign next_idx = bit_idx + 4'd1;

   // The line is driven from a register loaded with the upcoming bit at each
   // bit boundary, so the start bit appears on the clock after acceptance.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         tx_serial <= 1'b1;
         tx_ready  <= 1'b1;
         tx_busy   <= 1'b0;
         done_flag <= 1'b0;
         frame_out <= 11'h7FF;
         baud_cnt  <= '0;
         bit_idx   <= '0;
      end else begin
         done_flag <= 1'b0;
         case (state)
            IDLE: begin
               tx_serial <= 1'b1;
               if (tx_start && tx_ready) begin
                  frame_out <= {1'b1, par, tx_data, 1'b0};
                  bit_idx   <= '0;
                  baud_cnt  <= '0;
                  tx_serial <= 1'b0;
                  tx_ready  <= 1'b0;
                  tx_busy   <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  if (bit_idx == LAST_BIT) begin
                     tx_serial <= 1'b1;
                     tx_busy   <= 1'b0;
                     done_flag <= 1'b1;
                     state     <= DONE;
                  end else begin
                     bit_idx   <= next_idx;
                     tx_serial <= frame_out[next_idx];
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            DONE: begin
               tx_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: table of frames on even/odd parity instances plus
// hand-written handshake, back-to-back and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_framer;

   localparam int CPB        = 4;
   localparam int FRAME_CLKS = 11 * CPB;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_e, start_o;
   logic [7:0]  data_e, data_o;
   logic        ready_e, busy_e, line_e, done_e;
   logic        ready_o, busy_o, line_o, done_o;
   logic [10:0] frame_e, frame_o;

   always #5 clk = ~clk;

   uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
      .clk(clk), .reset_n(reset_n), .tx_start(start_e), .tx_data(data_e),
      .tx_ready(ready_e), .tx_busy(busy_e), .tx_serial(line_e),
      .done_flag(done_e), .frame_out(frame_e));

   uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .reset_n(reset_n), .tx_start(start_o), .tx_data(data_o),
      .tx_ready(ready_o), .tx_busy(busy_o), .tx_serial(line_o),
      .done_flag(done_o), .frame_out(frame_o));

   typedef struct {
      logic        odd;
      logic [7:0]  data;
      logic [10:0] frame;
   } vec_t;

   typedef struct {
      logic [10:0] line_bits;
      int          done_cycle;
      int          done_cnt;
      int          glitches;
      int          busy_bad;
      int          wait_cycles;
      logic [2:0]  end_state;
   } res_t;

   int          total = 0;
   int          bad = 0;
   logic [10:0] expq[$];
   int          rx_frames = 0;
   int          rx_aborts = 0;
   int          expect_rx = 0;

   function automatic logic [10:0] modelFrame(input logic odd, input logic [7:0] d);
      logic p;
      p = (^d) ^ odd;
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Loopback receiver on the even instance: samples mid-bit, pops the scoreboard.
   initial begin : receiver
      int          pos;
      logic [10:0] bits;
      logic [10:0] want;
      pos  = 0;
      bits = '0;
      forever begin
         @(negedge clk);
         if (pos == 0) begin
            if (busy_e === 1'b1 && line_e === 1'b0) pos = 1;
         end else begin
            pos++;
         end
         if (pos != 0) begin
            if (busy_e !== 1'b1) begin
               if (expq.size() > 0) void'(expq.pop_front());
               rx_aborts++;
               pos = 0;
            end else if ((pos - 2) % CPB == 0) begin
               bits[(pos - 2) / CPB] = line_e;
               if ((pos - 2) / CPB == 10) begin
                  checkOutput("rx_has_expected", 32'(expq.size() > 0), 32'd1);
                  if (expq.size() > 0) begin
                     want = expq.pop_front();
                     checkOutput("rx_frame", 32'(bits), 32'(want));
                  end
                  rx_frames++;
                  pos = 0;
               end
            end
         end
      end
   end

   // Called at a negedge; waits for ready, then follows the frame through cycle 45.
   task automatic applyStimulus(input logic odd, input logic [7:0] d, input logic keep,
                                input logic [7:0] next_d, input int pulse_at, output res_t r);
      logic rdy, l, b, dn;
      r = '{default: 0};
      if (odd) begin start_o = 1'b1; data_o = d; end
      else begin start_e = 1'b1; data_e = d; end
      rdy = odd ? ready_o : ready_e;
      while (rdy !== 1'b1 && r.wait_cycles < 200) begin
         @(negedge clk);
         r.wait_cycles++;
         rdy = odd ? ready_o : ready_e;
      end
      checkOutput("accept_timeout", 32'(r.wait_cycles < 200), 32'd1);
      if (!odd) begin
         expq.push_back(modelFrame(1'b0, d));
         expect_rx++;
      end
      for (int c = 1; c <= FRAME_CLKS + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            if (odd) begin data_o = next_d; if (!keep) start_o = 1'b0; end
            else begin data_e = next_d; if (!keep) start_e = 1'b0; end
         end
         if (!odd && c == pulse_at) begin start_e = 1'b1; data_e = 8'h3C; end
         if (!odd && c == pulse_at + 1) begin start_e = 1'b0; data_e = next_d; end
         l   = odd ? line_o : line_e;
         b   = odd ? busy_o : busy_e;
         rdy = odd ? ready_o : ready_e;
         dn  = odd ? done_o : done_e;
         if (dn === 1'b1) begin
            r.done_cnt++;
            if (r.done_cycle == 0) r.done_cycle = c;
         end
         if (c <= FRAME_CLKS) begin
            if ((c - 1) % CPB == 0) r.line_bits[(c - 1) / CPB] = l;
            else if (l !== r.line_bits[(c - 1) / CPB]) r.glitches++;
            if (b !== 1'b1 || rdy !== 1'b0) r.busy_bad++;
         end else begin
            r.end_state = {rdy, b, l};
         end
      end
   endtask

   task automatic checkFrame(input string name, input logic odd, input res_t r, input logic [10:0] exp_frame);
      $display("[TB] checking %s", name);
      checkOutput({name, "_frame_out"}, 32'(odd ? frame_o : frame_e), 32'(exp_frame));
      checkOutput({name, "_line_bits"}, 32'(r.line_bits), 32'(exp_frame));
      checkOutput({name, "_done_cycle"}, 32'(r.done_cycle), 32'(FRAME_CLKS + 1));
      checkOutput({name, "_done_pulses"}, 32'(r.done_cnt), 32'd1);
      checkOutput({name, "_bit_hold"}, 32'(r.glitches), 32'd0);
      checkOutput({name, "_busy_ready"}, 32'(r.busy_bad), 32'd0);
      checkOutput({name, "_done_state"}, 32'(r.end_state), 32'b001);
   endtask

   vec_t vecs[5];
   res_t res;
   int   cnt;

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      vecs[0] = '{1'b0, 8'hA5, 11'h54A};
      vecs[1] = '{1'b0, 8'h01, 11'h602};
      vecs[2] = '{1'b1, 8'h00, 11'h600};
      vecs[3] = '{1'b1, 8'hFF, 11'h7FE};
      vecs[4] = '{1'b1, 8'hA5, 11'h74A};

      // Reset held with tx_start asserted: nothing may be sent.
      reset_n = 1'b0;
      start_e = 1'b1; data_e = 8'hA5;
      start_o = 1'b1; data_o = 8'h5A;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (line_e !== 1'b1 || line_o !== 1'b1 || busy_e !== 1'b0 || done_e !== 1'b0) cnt++;
      end
      checkOutput("reset_activity", 32'(cnt), 32'd0);
      checkOutput("reset_outputs_even", 32'({ready_e, busy_e, line_e, done_e}), 32'b1010);
      checkOutput("reset_frame_even", 32'(frame_e), 32'h7FF);
      checkOutput("reset_frame_odd", 32'(frame_o), 32'h7FF);
      start_e = 1'b0;
      start_o = 1'b0;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idle_after_reset", 32'({ready_e, busy_e, line_e}), 32'b101);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].odd, vecs[i].data, 1'b0, ~vecs[i].data, -10, res);
         checkFrame($sformatf("vec%0d", i), vecs[i].odd, res, vecs[i].frame);
         @(negedge clk);
      end

      // A tx_start pulse while busy must be dropped.
      applyStimulus(1'b0, 8'h55, 1'b0, 8'hAA, 10, res);
      checkFrame("ignore_while_busy", 1'b0, res, 11'h4AA);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (line_e !== 1'b1 || busy_e !== 1'b0 || ready_e !== 1'b1) cnt++;
      end
      checkOutput("no_queued_frame", 32'(cnt), 32'd0);

      // tx_start held high: second frame starts after DONE + one IDLE clock.
      applyStimulus(1'b0, 8'hC3, 1'b1, 8'h18, -10, res);
      checkFrame("hold_first", 1'b0, res, 11'h586);
      @(negedge clk);
      checkOutput("hold_idle_clock", 32'({ready_e, busy_e, line_e}), 32'b101);
      applyStimulus(1'b0, 8'h18, 1'b0, 8'h00, -10, res);
      checkOutput("hold_gap", 32'(res.wait_cycles), 32'd0);
      checkFrame("hold_second", 1'b0, res, 11'h430);
      @(negedge clk);

      // Reset during data bit 3 truncates the frame with no done pulse.
      start_e = 1'b1;
      data_e  = 8'h00;
      expq.push_back(modelFrame(1'b0, 8'h00));
      checkOutput("abort_ready", 32'(ready_e), 32'd1);
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c == 1) start_e = 1'b0;
      end
      checkOutput("abort_bit3_low", 32'(line_e), 32'd0);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_outputs", 32'({ready_e, busy_e, line_e, done_e}), 32'b1010);
      checkOutput("abort_frame_out", 32'(frame_e), 32'h7FF);
      reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done_e === 1'b1 || line_e !== 1'b1) cnt++;
      end
      checkOutput("abort_no_done", 32'(cnt), 32'd0);
      checkOutput("abort_seen", 32'(rx_aborts), 32'd1);
      applyStimulus(1'b0, 8'h7E, 1'b0, 8'h81, -10, res);
      checkFrame("after_abort", 1'b0, res, 11'h4FC);

      repeat (4) @(negedge clk);
      checkOutput("rx_frame_count", 32'(rx_frames), 32'(expect_rx));
      checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
